seq_alu: RTL and testbench

Parametrised, handshaked successor to the 4-bit combinational ALU.
- Accepts one operation at a time over valid/ready and keeps the existing opcode map and 8-bit flag layout.
- Adds iterative multiply and divide, a high-half result, and registered results and flags.
- Sits between the register file/decoder and writeback. The flag register is read by the branch unit.

---
 rtl/seq_alu_pkg.sv | 32 +++
 rtl/seq_alu_muldiv.sv | 104 ++++++++++
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode map, flag bit positions, FSM states.
// SEQ_ALU_DIV_EN selects whether opcode 1100 runs the iterative divider.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'b0000,
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_NOR, OP_XOR,
      OP_RSH, OP_LSH, OP_LDI, OP_ADI, OP_MUL, OP_DIV, OP_CMP,
      OP_U14, OP_U15
   } op_e;

   localparam int FLAG_Z  = 0;
   localparam int FLAG_C  = 1;
   localparam int FLAG_N  = 2;
   localparam int FLAG_V  = 3;
   localparam int FLAG_EQ = 4;
   localparam int FLAG_NE = 5;
   localparam int FLAG_GT = 6;
   localparam int FLAG_LT = 7;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   // Ops that go through the iterative unit instead of the single-cycle datapath.
   function automatic logic is_multi(op_e op);
`ifdef SEQ_ALU_DIV_EN
      return (op == OP_MUL) || (op == OP_DIV);
`else
      return op == OP_MUL;
`endif
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unit: shift-add unsigned multiply, and restoring divide when
// SEQ_ALU_DIV_EN is defined. done pulses one cycle after WIDTH iterations.
module seq_alu_muldiv #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_ALU_DIV_EN
   input  logic             div_mode,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);
   import seq_alu_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   logic             run_q, run_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic [WIDTH:0]   mul_sum;
`ifdef SEQ_ALU_DIV_EN
   logic             div_q, div_d;
   logic [WIDTH:0]   div_shift;
`endif

   assign done   = run_q && (cnt_q == CW'(WIDTH));
   assign res_hi = hi_q;
   assign res_lo = lo_q;

   always_comb begin
      run_d   = run_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      mul_sum = {1'b0, hi_q} + {1'b0, b_q};
`ifdef SEQ_ALU_DIV_EN
      div_d     = div_q;
      div_shift = {hi_q, lo_q[WIDTH-1]};
`endif
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         hi_d  = '0;
         lo_d  = a;
         b_d   = b;
`ifdef SEQ_ALU_DIV_EN
         div_d = div_mode;
`endif
      end else if (done) begin
         run_d = 1'b0;
      end else if (run_q) begin
         cnt_d = cnt_q + CW'(1);
         // {hi,lo} shifts right; lo holds the unconsumed multiplier bits.
         if (lo_q[0]) begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
         end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
         end
`ifdef SEQ_ALU_DIV_EN
         // hi is the partial remainder, lo shifts dividend out and quotient in.
         if (div_q) begin
            if (div_shift >= {1'b0, b_q}) begin
               hi_d = div_shift[WIDTH-1:0] - b_q;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
         div_q <= 1'b0;
`endif
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         b_q   <= b_d;
`ifdef SEQ_ALU_DIV_EN
         div_q <= div_d;
`endif
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: one op in flight, registered result/flags held until taken.
// Build with SEQ_ALU_DIV_EN to make opcode 1100 an iterative divide.
module seq_alu #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] o_hi,
   output logic [7:0]       flags
);
   import seq_alu_pkg::*;

   // Handshake: an op moves when in_valid && in_ready at a rising edge; the
   // result moves when out_valid && out_ready at a rising edge.
   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, o_q, o_d, o_hi_q, o_hi_d;
   logic [7:0]       flags_q, flags_d;
   logic             out_valid_q, out_valid_d;

   logic             md_start, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] res_o, res_hi;
   logic [7:0]       res_f;
   logic             zn;
   logic [WIDTH:0]   sum, diff;

   assign in_ready  = rst_n && (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign o         = o_q;
   assign o_hi      = o_hi_q;
   assign flags     = flags_q;

   seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (md_start),
`ifdef SEQ_ALU_DIV_EN
      .div_mode (op_e'(opcode) == OP_DIV),
`endif
      .a        (a),
      .b        (b),
      .done     (md_done),
      .res_hi   (md_hi),
      .res_lo   (md_lo)
   );

   always_comb begin
      sum    = {1'b0, a_q} + {1'b0, b_q};
      diff   = {1'b0, a_q} - {1'b0, b_q};
      res_o  = '0;
      res_hi = '0;
      res_f  = '0;
      zn     = 1'b0;
      res_f[FLAG_EQ] = (a_q == b_q);
      res_f[FLAG_NE] = (a_q != b_q);
      res_f[FLAG_GT] = (a_q > b_q);
      res_f[FLAG_LT] = (a_q < b_q);
      case (op_q)
         OP_ADD, OP_ADI: begin
            res_o         = sum[WIDTH-1:0];
            res_f[FLAG_C] = sum[WIDTH];
            res_f[FLAG_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            zn            = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            // CMP reports the full subtract flags but drives a zero result.
            res_o          = (op_q == OP_SUB) ? diff[WIDTH-1:0] : '0;
            res_f[FLAG_Z]  = (diff[WIDTH-1:0] == '0);
            res_f[FLAG_N]  = diff[WIDTH-1];
            res_f[FLAG_C]  = !diff[WIDTH];
            res_f[FLAG_V]  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            res_f[FLAG_EQ] = res_f[FLAG_Z];
            res_f[FLAG_NE] = !res_f[FLAG_Z];
            res_f[FLAG_GT] = !res_f[FLAG_Z] && !diff[WIDTH];
            res_f[FLAG_LT] = diff[WIDTH];
         end
         OP_AND: begin res_o = a_q & b_q;    zn = 1'b1; end
         OP_ORR: begin res_o = a_q | b_q;    zn = 1'b1; end
         OP_NOR: begin res_o = ~(a_q | b_q); zn = 1'b1; end
         OP_XOR: begin res_o = a_q ^ b_q;    zn = 1'b1; end
         OP_RSH: begin
            res_o         = {1'b0, a_q[WIDTH-1:1]};
            res_f[FLAG_C] = a_q[0];
            zn            = 1'b1;
         end
         OP_LSH: begin
            res_o         = {a_q[WIDTH-2:0], 1'b0};
            res_f[FLAG_C] = a_q[WIDTH-1];
            zn            = 1'b1;
         end
         OP_LDI: res_o = b_q;
         OP_MUL: begin
            res_o         = md_lo;
            res_hi        = md_hi;
            res_f[FLAG_Z] = ({md_hi, md_lo} == '0);
            res_f[FLAG_C] = (md_hi != '0);
            res_f[FLAG_V] = (md_hi != '0);
            res_f[FLAG_N] = md_lo[WIDTH-1];
         end
`ifdef SEQ_ALU_DIV_EN
         OP_DIV: begin
            res_o         = md_lo;
            res_hi        = md_hi;
            res_f[FLAG_Z] = (md_lo == '0);
            res_f[FLAG_N] = md_lo[WIDTH-1];
            res_f[FLAG_V] = (b_q == '0);
         end
`endif
         default: ;
      endcase
      if (zn) begin
         res_f[FLAG_Z] = (res_o == '0);
         res_f[FLAG_N] = res_o[WIDTH-1];
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      o_d         = o_q;
      o_hi_d      = o_hi_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      md_start    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_d     = op_e'(opcode);
               a_d      = a;
               b_d      = b;
               md_start = is_multi(op_e'(opcode));
               state_d  = BUSY;
            end
         end
         BUSY: begin
            if (!is_multi(op_q) || md_done) begin
               o_d         = res_o;
               o_hi_d      = res_hi;
               flags_d     = res_f;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_NOP;
         a_q         <= '0;
         b_q         <= '0;
         o_q         <= '0;
         o_hi_q      <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         o_q         <= o_d;
         o_hi_q      <= o_hi_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=4); expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

   localparam int W  = 4;
   localparam int EW = 2 * W + 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   opcode;
   logic [W-1:0] a, b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] o, o_hi;
   logic [7:0]   flags;

   logic [EW-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .o_hi      (o_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit multi_op(input int op);
`ifdef SEQ_ALU_DIV_EN
      return (op == 11) || (op == 12);
`else
      return op == 11;
`endif
   endfunction

   // Reference model packed as {o_hi, o, flags}.
   function automatic logic [EW-1:0] model(input int op, input int av, input int bv);
      int mask = (1 << W) - 1;
      int half = 1 << (W - 1);
      int ov = 0;
      int hv = 0;
      int r, sa, sb;
      logic [7:0] f = 8'h00;
      bit zn = 0;
      logic [W-1:0] o_s, h_s;
      sa = (av >= half) ? av - (1 << W) : av;
      sb = (bv >= half) ? bv - (1 << W) : bv;
      f[4] = (av == bv); f[5] = (av != bv); f[6] = (av > bv); f[7] = (av < bv);
      case (op)
         1, 10: begin
            r = av + bv; ov = r & mask; f[1] = (r > mask);
            f[3] = ((sa + sb) >= half) || ((sa + sb) < -half); zn = 1;
         end
         2, 13: begin
            r = av - bv; ov = r & mask;
            f[0] = (ov == 0); f[2] = ((ov & half) != 0); f[1] = (av >= bv);
            f[3] = ((sa - sb) >= half) || ((sa - sb) < -half);
            if (op == 13) ov = 0;
         end
         3: begin ov = av & bv; zn = 1; end
         4: begin ov = av | bv; zn = 1; end
         5: begin ov = ~(av | bv) & mask; zn = 1; end
         6: begin ov = av ^ bv; zn = 1; end
         7: begin ov = av >> 1; f[1] = ((av & 1) != 0); zn = 1; end
         8: begin ov = (av << 1) & mask; f[1] = (((av >> (W - 1)) & 1) != 0); zn = 1; end
         9: ov = bv;
         11: begin
            r = av * bv; ov = r & mask; hv = r >> W;
            f[0] = (r == 0); f[1] = (hv != 0); f[3] = (hv != 0); f[2] = ((ov & half) != 0);
         end
`ifdef SEQ_ALU_DIV_EN
         12: begin
            if (bv == 0) begin ov = mask; hv = av; f[3] = 1'b1; end
            else begin ov = av / bv; hv = av % bv; end
            f[0] = (ov == 0); f[2] = ((ov & half) != 0);
         end
`endif
         default: ;
      endcase
      if (zn) begin f[0] = (ov == 0); f[2] = ((ov & half) != 0); end
      o_s = ov[W-1:0];
      h_s = hv[W-1:0];
      return {h_s, o_s, f};
   endfunction

   // Drive one op, check latency and hold behaviour, then complete the handshake.
   task automatic do_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [EW-1:0] exp, input int lat, input int hold);
      int cyc;
      logic [EW-1:0] e;
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      opcode = op; a = av; b = bv; in_valid = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
      opcode = 4'($urandom_range(0, 15));
      a = W'($urandom_range(0, (1 << W) - 1));
      b = W'($urandom_range(0, (1 << W) - 1));
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         check("in_ready_busy", in_ready, 0);
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, lat);
      e = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         check("out_valid", out_valid, 1);
         check("in_ready_done", in_ready, 0);
         check("o", o, e[W+7:8]);
         check("o_hi", o_hi, e[EW-1:W+8]);
         check("flags", flags, e[7:0]);
         if (h < hold) begin @(posedge clk); #1; end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
      check("in_ready_after", in_ready, 1);
   endtask

   initial begin
      int op, av, bv;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opcode = 4'h0; a = '0; b = '0;
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_o", o, 0);
      check("rst_o_hi", o_hi, 0);
      check("rst_flags", flags, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 check("post_rst_in_ready", in_ready, 1);

      do_op(4'b0001, 4'd9, 4'd8, {4'h0, 4'h1, 8'h6A}, 1, 0);
      do_op(4'b0010, 4'd3, 4'd5, {4'h0, 4'hE, 8'hA4}, 1, 0);
      do_op(4'b1011, 4'd13, 4'd11, {4'h8, 4'hF, 8'h6E}, W + 1, 0);
`ifdef SEQ_ALU_DIV_EN
      do_op(4'b1100, 4'd13, 4'd4, {4'h1, 4'h3, 8'h60}, W + 1, 0);
      do_op(4'b1100, 4'd13, 4'd0, {4'hD, 4'hF, 8'h6C}, W + 1, 0);
`else
      do_op(4'b1100, 4'd13, 4'd0, {4'h0, 4'h0, 8'h60}, 1, 0);
`endif
      do_op(4'b1101, 4'd7, 4'd7, {4'h0, 4'h0, 8'h13}, 1, 3);
      do_op(4'b1001, 4'd2, 4'd6, {4'h0, 4'h6, 8'hA0}, 1, 1);

      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 15);
         av = $urandom_range(0, (1 << W) - 1);
         bv = $urandom_range(0, (1 << W) - 1);
         do_op(4'(op), W'(av), W'(bv), model(op, av, bv),
               multi_op(op) ? W + 1 : 1, $urandom_range(0, 2));
      end

      // Reset in the middle of a multiply discards it immediately.
      do_op(4'b0001, 4'd9, 4'd8, {4'h0, 4'h1, 8'h6A}, 1, 0);
      @(negedge clk);
      opcode = 4'b1011; a = 4'd13; b = 4'd11; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_o", o, 0);
      check("mid_rst_o_hi", o_hi, 0);
      check("mid_rst_flags", flags, 0);
      check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 check("mid_rel_in_ready", in_ready, 1);
      repeat (W + 2) begin
         @(posedge clk); #1;
         check("mid_rel_no_valid", out_valid, 0);
      end
      do_op(4'b0001, 4'd9, 4'd8, {4'h0, 4'h1, 8'h6A}, 1, 0);
      do_op(4'b1011, 4'd5, 4'd3, model(11, 5, 3), W + 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
